// File: rtl/divider_prog.sv
// divider_prog: runtime-programmable integer clock divider.
// The divide factor can be changed while running. A new factor takes effect
// only at an output-period boundary, so clk_o never produces a runt pulse.
// When en drops, the divider finishes the current period before it stops.
// Each output period ends with a one-cycle tick_o. A load with a factor
// below 2 is rejected and reported on cfg_err_o.
// Optional build macro DIVIDER_PROG_DUTY50_EN: gives odd factors a true 50%
// duty cycle by ANDing clk_p with a copy of itself captured on the negedge.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | stopped; clk_o held low; a pending factor is applied freely
// ST_RUN   | dividing; a new period starts at every wrap
// ST_DRAIN | en dropped; finish the current period, then go to IDLE
module divider_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_factor,
  output logic             clk_o,
  output logic             tick_o,
  output logic             cfg_err_o,
  output logic [DIV_W-1:0] cur_div_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W:0]   ONE_X   = (DIV_W+1)'(1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_p_q, clk_p_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic             load_ok;
  logic             wrap;
  logic [DIV_W:0]   half_d;

  // Next-state, counter, factor hand-over and registered output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    load_ok    = div_load && (div_factor >= MIN_DIV);
    cfg_err_d  = div_load && (div_factor < MIN_DIV);
    pend_div_d = load_ok ? div_factor : pend_div_q;
    pend_vld_d = pend_vld_q | load_ok;
    wrap       = (state_q != ST_IDLE) && (cnt_q == cur_div_q - ONE);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // A stopped divider has no period to protect, so apply at once.
        if (pend_vld_q) begin
          cur_div_d  = pend_div_q;
          pend_vld_d = load_ok;
        end
        if (en) state_d = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        if (wrap) begin
          cnt_d   = '0;
          state_d = en ? ST_RUN : ST_IDLE;
          // A load arriving on the wrap cycle itself still makes this boundary.
          if (pend_vld_q || load_ok) cur_div_d = pend_div_d;
          pend_vld_d = 1'b0;
        end else begin
          cnt_d   = cnt_q + ONE;
          state_d = en ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Decode the outputs from the next state so that they come straight from flops.
    half_d  = ({1'b0, cur_div_d} + ONE_X) >> 1;
    clk_p_d = (state_d != ST_IDLE) && ({1'b0, cnt_d} < half_d);
    tick_d  = (state_d != ST_IDLE) && (cnt_d == cur_div_d - ONE);
  end

  // State and output registers; reset forces clk_o low asynchronously.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_div_q  <= DEF_DIV;
      pend_div_q <= DEF_DIV;
      pend_vld_q <= 1'b0;
      clk_p_q    <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      clk_p_q    <= clk_p_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef DIVIDER_PROG_DUTY50_EN
  logic clk_n_q;
  logic clk_n_d;

  assign clk_n_d = clk_p_q;

  // Half-cycle-delayed copy of clk_p, used to trim the odd-N high phase.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) clk_n_q <= 1'b0;
    else        clk_n_q <= clk_n_d;
  end

  // Parity comes from cur_div_q, which only changes at a period boundary.
  assign clk_o = cur_div_q[0] ? (clk_p_q & clk_n_q) : clk_p_q;
`else
  assign clk_o = clk_p_q;
`endif

  assign tick_o    = tick_q;
  assign cfg_err_o = cfg_err_q;
  assign cur_div_o = cur_div_q;

endmodule

// File: tb/tb_divider_prog.sv
// Directed bench for divider_prog. Outputs are normally sampled 1 ns after
// the falling edge of clk_in; a few samples are taken just after the rising
// edge to see the leading edge of clk_o.
`timescale 1ns/1ps
module tb_divider_prog;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       en;
  logic       div_load;
  logic [7:0] div_factor;
  logic       clk_o;
  logic       tick_o;
  logic       cfg_err_o;
  logic [7:0] cur_div_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] co, tk;

`ifdef DIVIDER_PROG_DUTY50_EN
  localparam logic [31:0] ODD_RISE = 32'd0;
`else
  localparam logic [31:0] ODD_RISE = 32'd1;
`endif

  divider_prog #(.DIV_W(8), .DEFAULT_DIV(5)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .div_load   (div_load),
    .div_factor (div_factor),
    .clk_o      (clk_o),
    .tick_o     (tick_o),
    .cfg_err_o  (cfg_err_o),
    .cur_div_o  (cur_div_o)
  );

  always #10 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_in);
    #1;
  endtask

  task automatic run_cap(input int n, output logic [31:0] c, output logic [31:0] t);
    c = '0;
    t = '0;
    for (int i = 0; i < n; i++) begin
      cyc();
      c[i] = clk_o;
      t[i] = tick_o;
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; div_load = 1'b0; div_factor = 8'd0;
    #2 rst_n = 1'b0;
    cyc(); cyc();
    check("rst_clk_o",   32'(clk_o),     32'd0);
    check("rst_tick",    32'(tick_o),    32'd0);
    check("rst_cfg_err", 32'(cfg_err_o), 32'd0);
    check("rst_cur_div", 32'(cur_div_o), 32'd5);
    rst_n = 1'b1;
    cyc();
    check("idle_clk_o",  32'(clk_o),     32'd0);

    // 1: default N=5 -> 3 high / 2 low, tick on the last cycle
    en = 1'b1;
    run_cap(10, co, tk);
    check("t1_clk_pat",  co, 32'h0E7);
    check("t1_tick_pat", tk, 32'h210);
    check("t1_cur_div",  32'(cur_div_o), 32'd5);
    @(posedge clk_in); #1;
    check("t1_rise_edge", 32'(clk_o), ODD_RISE);
    cyc();
    check("t1_cnt0_high", 32'(clk_o), 32'd1);

    // 2: load 4 at cnt=1; the current period still completes with N=5
    cyc();
    div_load = 1'b1; div_factor = 8'd4;
    cyc();
    div_load = 1'b0;
    check("t2_cur_before", 32'(cur_div_o), 32'd5);
    cyc(); cyc();
    check("t2_old_tick",  32'(tick_o),    32'd1);
    check("t2_cur_wrap-1", 32'(cur_div_o), 32'd5);
    @(posedge clk_in); #1;
    check("t2_cur_after", 32'(cur_div_o), 32'd4);
    check("t2_rise_edge", 32'(clk_o),     32'd1);
    run_cap(8, co, tk);
    check("t2_clk_pat",  co, 32'h33);
    check("t2_tick_pat", tk, 32'h88);

    // Load 5 on the wrap cycle: it is applied at that same wrap
    div_load = 1'b1; div_factor = 8'd5;
    cyc();
    div_load = 1'b0;
    check("t3_wrap_load", 32'(cur_div_o), 32'd5);

    // 3: illegal factors 1 and 0
    div_load = 1'b1; div_factor = 8'd1;
    cyc();
    div_load = 1'b0;
    check("t3_err_f1",  32'(cfg_err_o), 32'd1);
    cyc();
    check("t3_err_clr", 32'(cfg_err_o), 32'd0);
    div_load = 1'b1; div_factor = 8'd0;
    cyc();
    div_load = 1'b0;
    check("t3_err_f0",  32'(cfg_err_o), 32'd1);
    cyc();
    check("t3_err_clr2", 32'(cfg_err_o), 32'd0);
    check("t3_tick",     32'(tick_o),    32'd1);
    run_cap(5, co, tk);
    check("t3_clk_pat",  co, 32'h07);
    check("t3_tick_pat", tk, 32'h10);
    check("t3_cur_div",  32'(cur_div_o), 32'd5);

    // 4: N=6, en dropped at cnt=2 -> the period drains, then IDLE
    div_load = 1'b1; div_factor = 8'd6;
    cyc();
    div_load = 1'b0;
    check("t4_cur_div", 32'(cur_div_o), 32'd6);
    cyc(); cyc();
    check("t4_cnt2_high", 32'(clk_o), 32'd1);
    en = 1'b0;
    run_cap(6, co, tk);
    check("t4_drain_clk",  co, 32'h00);
    check("t4_drain_tick", tk, 32'h04);

    // en re-raised during DRAIN at cnt=4 -> no gap in clk_o
    en = 1'b1;
    cyc(); cyc(); cyc();
    en = 1'b0;
    cyc(); cyc();
    en = 1'b1;
    run_cap(12, co, tk);
    check("t4_resume_clk",  co, 32'h38E);
    check("t4_resume_tick", tk, 32'h041);

    // 6: N=7, asynchronous reset while clk_o is high
    div_load = 1'b1; div_factor = 8'd7;
    cyc();
    div_load = 1'b0;
    check("t6_cur_before", 32'(cur_div_o), 32'd6);
    cyc();
    check("t6_cur_after", 32'(cur_div_o), 32'd7);
    cyc();
    check("t6_high", 32'(clk_o), 32'd1);
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("t6_async_clk", 32'(clk_o),     32'd0);
    check("t6_async_div", 32'(cur_div_o), 32'd5);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t6_idle_clk", 32'(clk_o),     32'd0);
    check("t6_idle_div", 32'(cur_div_o), 32'd5);
    cyc();
    check("t6_idle_clk2", 32'(clk_o), 32'd0);
    en = 1'b1;
    run_cap(5, co, tk);
    check("t6_rerun_clk",  co, 32'h07);
    check("t6_rerun_tick", tk, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
